// File: rtl/axi4_lite_regbank_pkg.sv
// axi4_lite_regbank_pkg
// Shared constants for the register bank: byte offsets of every register,
// derived word indices, the ID value, reset values and the STATUS width.
// No ports; imported by the interface, the status sub-module and the top.
package axi4_lite_regbank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned STATUS_W = 8;

  // Byte offsets of the register map (offset bits [5:0]).
  localparam logic [5:0] OFF_ID       = 6'h00;
  localparam logic [5:0] OFF_CTRL     = 6'h04;
  localparam logic [5:0] OFF_STATUS   = 6'h08;
  localparam logic [5:0] OFF_COUNT    = 6'h0C;
  localparam logic [5:0] OFF_SCRATCH0 = 6'h10;

  // Word indices (offset[4:2]); offset[5]=1 is the error window 0x20-0x3C.
  localparam logic [2:0] IDX_ID     = OFF_ID[4:2];
  localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_COUNT  = OFF_COUNT[4:2];

  localparam logic [DATA_W-1:0]   ID_VALUE    = 32'hA41E_0001;
  localparam logic [1:0]          RST_CTRL    = 2'b00;
  localparam logic [STATUS_W-1:0] RST_STATUS  = '0;
  localparam logic [DATA_W-1:0]   RST_COUNT   = '0;
  localparam logic [DATA_W-1:0]   RST_SCRATCH = '0;

  // CTRL bit positions.
  localparam int unsigned CTRL_CNT_EN = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

endpackage

// File: rtl/axi4_lite_regbank_if.sv
// axi4_lite_regbank_if
// Memory-side access bus of the register bank.
//   iCE/iRD/iWR : chip enable, read and write request (master -> slave)
//   iADDR       : byte address,  iWDATA : write data   (master -> slave)
//   oDATA/oERR  : registered read data and error flag  (slave -> master)
// Handshake: there is no back-pressure. A read is iCE&iRD&!iWR, a write is
// iCE&iRD&iWR, both accepted in the cycle presented; oDATA/oERR answer one
// cycle later and hold until the next accepted access.
interface axi4_lite_regbank_if;
  import axi4_lite_regbank_pkg::*;

  logic              iCE;
  logic              iRD;
  logic              iWR;
  logic [ADDR_W-1:0] iADDR;
  logic [DATA_W-1:0] iWDATA;
  logic [DATA_W-1:0] oDATA;
  logic              oERR;

  modport master (output iCE, iRD, iWR, iADDR, iWDATA, input oDATA, oERR);
  modport slave  (input iCE, iRD, iWR, iADDR, iWDATA, output oDATA, oERR);
endinterface

// File: rtl/axi4_lite_regbank_status.sv
// axi4_lite_regbank_status
// Sticky event register with write-1-to-clear.
//   iCLK, iRST    : clock, synchronous active-high reset
//   iEVENT        : event pulses, each sets its bit
//   iCLR_MASK     : bits to clear, applied when iCLR is high
//   iCLR          : clear strobe
//   oSTATUS       : current sticky status
// A set and a clear on the same bit in the same cycle leave the bit at 1.
module axi4_lite_regbank_status
  import axi4_lite_regbank_pkg::*;
(
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [STATUS_W-1:0] iEVENT,
  input  logic [STATUS_W-1:0] iCLR_MASK,
  input  logic                iCLR,
  output logic [STATUS_W-1:0] oSTATUS
);

  logic [STATUS_W-1:0] status_q, status_d;

  always_comb begin
    status_d = status_q;
    if (iCLR) status_d = status_d & ~iCLR_MASK;
    // Events OR-ed in last so they win over a simultaneous clear.
    status_d = status_d | iEVENT;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) status_q <= RST_STATUS;
    else      status_q <= status_d;
  end

  assign oSTATUS = status_q;

endmodule

// File: rtl/axi4_lite_regbank.sv
// axi4_lite_regbank
// Small memory-mapped register bank: ID, CTRL, STATUS (sticky W1C events),
// COUNT (free-running counter) and four SCRATCH words.
//   iCLK, iRST : clock, synchronous active-high reset
//   bus        : axi4_lite_regbank_if.slave access port (iCE/iRD/iWR/iADDR/
//                iWDATA in, oDATA/oERR registered out)
//   iEVENT     : 8 event pulses into STATUS, sampled every cycle
//   oIRQ       : level interrupt, IRQ_EN & |STATUS
// Option macro AXI4_LITE_REGBANK_COUNTER_EN: when defined, COUNT and
// CTRL.CNT_EN are implemented; otherwise COUNT reads 0, CTRL bit0 reads 0,
// and writes to them are accepted without effect.
module axi4_lite_regbank
  import axi4_lite_regbank_pkg::*;
(
  input  logic                      iCLK,
  input  logic                      iRST,
  axi4_lite_regbank_if.slave        bus,
  input  logic [STATUS_W-1:0]       iEVENT,
  output logic                      oIRQ
);

  logic                rd_req, wr_req, addr_err, wr_ok;
  logic [2:0]          idx;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W-1:0]   count_rd;
  logic [STATUS_W-1:0] status;

  logic [1:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   scratch_q [4];
  logic [DATA_W-1:0]   scratch_d [4];
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;

  // Access decode. A write needs iRD as well as iWR.
  assign rd_req   = bus.iCE & bus.iRD & ~bus.iWR;
  assign wr_req   = bus.iCE & bus.iRD &  bus.iWR;
  assign addr_err = (|bus.iADDR[ADDR_W-1:6]) | bus.iADDR[5];
  assign idx      = bus.iADDR[4:2];
  assign wr_ok    = wr_req & ~addr_err;

  // Sticky event status.
  axi4_lite_regbank_status u_status (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iEVENT    (iEVENT),
    .iCLR_MASK (bus.iWDATA[STATUS_W-1:0]),
    .iCLR      (wr_ok && (idx == IDX_STATUS)),
    .oSTATUS   (status)
  );

`ifdef AXI4_LITE_REGBANK_COUNTER_EN
  logic [DATA_W-1:0] count_q, count_d;

  // A write wins over the increment; counting resumes from the written value.
  always_comb begin
    count_d = count_q;
    if (wr_ok && (idx == IDX_COUNT))  count_d = bus.iWDATA;
    else if (ctrl_q[CTRL_CNT_EN])     count_d = count_q + 32'd1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) count_q <= RST_COUNT;
    else      count_q <= count_d;
  end

  assign count_rd = count_q;
`else
  assign count_rd = '0;
`endif

  // CTRL and SCRATCH next state.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ok && (idx == IDX_CTRL)) begin
      ctrl_d[CTRL_IRQ_EN] = bus.iWDATA[CTRL_IRQ_EN];
`ifdef AXI4_LITE_REGBANK_COUNTER_EN
      ctrl_d[CTRL_CNT_EN] = bus.iWDATA[CTRL_CNT_EN];
`else
      ctrl_d[CTRL_CNT_EN] = 1'b0;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) scratch_d[i] = scratch_q[i];
    // idx[2] set selects SCRATCH0-3 within the valid window.
    if (wr_ok && idx[2]) scratch_d[idx[1:0]] = bus.iWDATA;
  end

  // Read mux.
  always_comb begin
    rdata = '0;
    case (idx)
      IDX_ID:     rdata = ID_VALUE;
      IDX_CTRL:   rdata = {30'd0, ctrl_q};
      IDX_STATUS: rdata = {{(DATA_W-STATUS_W){1'b0}}, status};
      IDX_COUNT:  rdata = count_rd;
      default:    rdata = scratch_q[idx[1:0]];
    endcase
  end

  // Response registers: reads update data and error, writes only the error.
  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (rd_req) begin
      data_d = addr_err ? '0 : rdata;
      err_d  = addr_err;
    end else if (wr_req) begin
      err_d  = addr_err;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ctrl_q <= RST_CTRL;
      data_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) scratch_q[i] <= RST_SCRATCH;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      err_q  <= err_d;
      for (int i = 0; i < 4; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign bus.oDATA = data_q;
  assign bus.oERR  = err_q;
  assign oIRQ      = ctrl_q[CTRL_IRQ_EN] & (|status);

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// tb_axi4_lite_regbank
// Self-checking bench for axi4_lite_regbank. Read expectations are pushed to
// exp_q as each read is driven; the response seen one cycle later is pushed
// to obs_q and each test drains and compares both queues.
module tb_axi4_lite_regbank;
  import axi4_lite_regbank_pkg::*;

  // Clock / reset
  logic                iCLK = 1'b0;
  logic                iRST;
  logic [STATUS_W-1:0] iEVENT;
  logic                oIRQ;

  axi4_lite_regbank_if bus ();

  axi4_lite_regbank dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .bus    (bus),
    .iEVENT (iEVENT),
    .oIRQ   (oIRQ)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [32:0] exp_q [$];
  logic [32:0] obs_q [$];
  string       name_q [$];
  logic [31:0] scr_m [4];

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic bus_cycle(input logic ce, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.iCE = ce; bus.iRD = rd; bus.iWR = wr; bus.iADDR = addr; bus.iWDATA = wdata;
    @(posedge iCLK); #1;
    bus.iCE = 1'b0; bus.iRD = 1'b0; bus.iWR = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, 1'b1, 1'b1, addr, data);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic exp_e, input string nm);
    exp_q.push_back({exp_e, exp_d});
    name_q.push_back(nm);
    bus_cycle(1'b1, 1'b1, 1'b0, addr, 32'h0);
    obs_q.push_back({bus.oERR, bus.oDATA});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  // Tests
  task automatic test_reset;
    iRST = 1'b1; iEVENT = '0;
    bus.iCE = 0; bus.iRD = 0; bus.iWR = 0; bus.iADDR = '0; bus.iWDATA = '0;
    idle(3);
    iRST = 1'b0;
    total_cnt++;
    if ({bus.oERR, bus.oDATA, oIRQ} !== 34'd0)
      $display("FAIL reset_outputs: got err=%0b data=%08h irq=%0b, expected all 0",
               bus.oERR, bus.oDATA, oIRQ);
    else pass_cnt++;
    do_read(32'h00, ID_VALUE, 1'b0, "id_read");
    do_read(32'h04, 32'h0, 1'b0, "ctrl_reset");
    do_read(32'h08, 32'h0, 1'b0, "status_reset");
    do_read(32'h1C, 32'h0, 1'b0, "scratch3_reset");
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_scratch;
    do_write(32'h14, 32'h0001_2345);
    do_read(32'h14, 32'h0001_2345, 1'b0, "scratch1_rt");
    do_read(32'h17, 32'h0001_2345, 1'b0, "scratch1_alias");
    for (int i = 0; i < 4; i++) begin
      scr_m[i] = $urandom;
      do_write(32'h10 + 32'(i * 4), scr_m[i]);
    end
    for (int i = 3; i >= 0; i--)
      do_read(32'h10 + 32'(i * 4) + 32'($urandom_range(0, 3)), scr_m[i], 1'b0, "scratch_rand");
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gating;
    do_read(32'h00, ID_VALUE, 1'b0, "id_before_hold");
    bus_cycle(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);  // read with iCE low
    total_cnt++;
    if (bus.oDATA !== ID_VALUE)
      $display("FAIL data_hold: got %08h, expected %08h", bus.oDATA, ID_VALUE);
    else pass_cnt++;
    bus_cycle(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_0001);  // write with iCE low
    bus_cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_0002);  // iWR without iRD
    do_write(32'h00, 32'h1234_5678);                     // ID is read-only
    total_cnt++;
    if (bus.oERR !== 1'b0)
      $display("FAIL id_write_err: got %0b, expected 0", bus.oERR);
    else pass_cnt++;
    do_read(32'h10, scr_m[0], 1'b0, "scratch0_gated");
    do_read(32'h00, ID_VALUE, 1'b0, "id_after_write");
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_error;
    scr_m[0] = 32'hCAFE_F00D;
    do_write(32'h10, scr_m[0]);
    do_read(32'h1000_0020, 32'h0, 1'b1, "err_read_high");
    idle(2);
    total_cnt++;
    if (bus.oERR !== 1'b1) $display("FAIL err_hold: got %0b, expected 1", bus.oERR);
    else pass_cnt++;
    do_read(32'h10, scr_m[0], 1'b0, "scratch0_before");
    do_write(32'h20, 32'h5555_AAAA);
    total_cnt++;
    if ({bus.oERR, bus.oDATA} !== {1'b1, scr_m[0]})
      $display("FAIL err_write: got err=%0b data=%08h, expected err=1 data=%08h",
               bus.oERR, bus.oDATA, scr_m[0]);
    else pass_cnt++;
    do_read(32'h10, scr_m[0], 1'b0, "scratch0_after_err");
    do_read(32'h3C, 32'h0, 1'b1, "err_read_3c");
    do_write(32'h0000_0050, 32'hFFFF_FFFF);  // aliases SCRATCH0 only if bit 6 were ignored
    do_read(32'h10, scr_m[0], 1'b0, "scratch0_no_alias");
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_status;
    do_write(32'h04, 32'h0000_0002);  // IRQ_EN
    total_cnt++;
    if (oIRQ !== 1'b0) $display("FAIL irq_idle: got %0b, expected 0", oIRQ);
    else pass_cnt++;
    iEVENT = 8'h05; idle(1); iEVENT = 8'h00;
    total_cnt++;
    if (oIRQ !== 1'b1) $display("FAIL irq_set: got %0b, expected 1", oIRQ);
    else pass_cnt++;
    do_read(32'h08, 32'h05, 1'b0, "status_events");
    iEVENT = 8'h01; do_write(32'h08, 32'h01); iEVENT = 8'h00;
    do_read(32'h08, 32'h05, 1'b0, "status_set_wins");
    do_write(32'h08, 32'h04);
    do_read(32'h08, 32'h01, 1'b0, "status_partial_clr");
    do_write(32'h08, 32'h05);
    do_read(32'h08, 32'h00, 1'b0, "status_cleared");
    total_cnt++;
    if (oIRQ !== 1'b0) $display("FAIL irq_cleared: got %0b, expected 0", oIRQ);
    else pass_cnt++;
    do_read(32'h04, 32'h02, 1'b0, "ctrl_irq_en");
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_counter;
`ifdef AXI4_LITE_REGBANK_COUNTER_EN
    do_write(32'h0C, 32'hFFFF_FFFE);
    do_write(32'h04, 32'h0000_0003);
    // Back-to-back reads see one increment per cycle from the cycle after enable.
    do_read(32'h0C, 32'hFFFF_FFFE, 1'b0, "count_start");
    do_read(32'h0C, 32'hFFFF_FFFF, 1'b0, "count_max");
    do_read(32'h0C, 32'h0000_0000, 1'b0, "count_wrap");
    do_read(32'h0C, 32'h0000_0001, 1'b0, "count_one");
    do_write(32'h0C, 32'h0000_0100);
    do_read(32'h0C, 32'h0000_0100, 1'b0, "count_write_prio");
    do_read(32'h0C, 32'h0000_0101, 1'b0, "count_resume");
    do_write(32'h04, 32'h0000_0002);  // counter off
    idle(3);
    do_read(32'h0C, 32'h0000_0103, 1'b0, "count_stopped");
    do_read(32'h04, 32'h0000_0002, 1'b0, "ctrl_cnt_off");
`else
    do_write(32'h0C, 32'h0000_1234);
    total_cnt++;
    if (bus.oERR !== 1'b0) $display("FAIL count_write_err: got %0b, expected 0", bus.oERR);
    else pass_cnt++;
    do_read(32'h0C, 32'h0, 1'b0, "count_absent");
    do_write(32'h04, 32'h0000_0003);
    idle(2);
    do_read(32'h04, 32'h0000_0002, 1'b0, "ctrl_bit0_absent");
    do_read(32'h0C, 32'h0, 1'b0, "count_still_zero");
`endif
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset;
    iEVENT = 8'h80; idle(1); iEVENT = 8'h00;   // IRQ_EN still set -> oIRQ high
    do_read(32'h00, ID_VALUE, 1'b0, "id_pre_reset");
    do_write(32'h24, 32'h0);                   // oERR=1, oDATA keeps ID
    total_cnt++;
    if ({oIRQ, bus.oERR, bus.oDATA} !== {1'b1, 1'b1, ID_VALUE})
      $display("FAIL pre_reset_state: got irq=%0b err=%0b data=%08h, expected irq=1 err=1 data=%08h",
               oIRQ, bus.oERR, bus.oDATA, ID_VALUE);
    else pass_cnt++;
    iRST = 1'b1;
    do_write(32'h04, 32'h0000_0003);
    iRST = 1'b0;
    total_cnt++;
    if ({oIRQ, bus.oERR, bus.oDATA} !== 34'd0)
      $display("FAIL mid_reset_outputs: got irq=%0b err=%0b data=%08h, expected all 0",
               oIRQ, bus.oERR, bus.oDATA);
    else pass_cnt++;
    do_read(32'h04, 32'h0, 1'b0, "ctrl_after_reset");
    do_read(32'h08, 32'h0, 1'b0, "status_after_reset");
    do_read(32'h10, 32'h0, 1'b0, "scratch0_after_reset");
    do_read(32'h0C, 32'h0, 1'b0, "count_after_reset");
    while (exp_q.size() > 0) begin
      logic [32:0] e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s: got err=%0b data=%08h, expected err=%0b data=%08h",
                            nm, o[32], o[31:0], e[32], e[31:0]);
      else pass_cnt++;
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_scratch();
    test_gating();
    test_error();
    test_status();
    test_counter();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
